muldiv_unit: RTL

- Iterative 32-bit unsigned multiply/divide unit in the execute stage of the multi-cycle CPU.
- Consumes the two operand values read from the 16-entry register file (Rs, Rt).
- Computes one result bit per cycle.
- Returns a result, its destination register index and a write-enable pulse to the register-file write port.
- The control FSM stalls on busy until done.

---
 rtl/muldiv_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit: one result bit per cycle,
// shift-add multiply and restoring divide sharing one {hi, lo} register pair.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   rs_value,
  input  logic [XLEN-1:0]   rt_value,
  input  logic [REG_AW-1:0] rd_in,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] rd_out,
  output logic              regwrite
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [1:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   step_hi;
  logic [XLEN-1:0]   step_lo;

  // One iteration of the selected algorithm; for divide, hi holds R and lo holds Q.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_rem  = {hi_q, lo_q[XLEN-1]};
    div_diff = div_rem[XLEN-1:0] - b_q;
    step_hi  = '0;
    step_lo  = '0;
    if (op_q[1] == 1'b0) begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (div_rem >= {1'b0, b_q}) begin
      step_hi = div_diff;
      step_lo = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_hi = div_rem[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_d     = op_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = rs_value;
          b_d     = rt_value;
          op_d    = op;
          rd_d    = rd_in;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = op[1] ? rs_value : rt_value;
          state_d = CALC;
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          // MULHU and REMU both live in hi; MUL and DIVU in lo.
          result_d = op_q[0] ? step_hi : step_lo;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign rd_out   = rd_q;
  assign regwrite = done && (rd_q != '0);

endmodule
